i2c_target_regfile: RTL and testbench

//  Synthesizable I2C target (slave) exposing a NUM_REGS x 8-bit register file to an external
//  I2C controller via mprj_io pads; replaces the sim-only target model on the user project bus.

---
 rtl/i2c_target_regfile.sv | 165 ++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with glitch-filtered pad inputs exposing an 8-bit register file,
// pointer write, auto-incrementing burst read/write with wrap, repeated START and a user port.
module i2c_target_regfile #(
   parameter logic [6:0] I2C_ADDR    = 7'h29,
   parameter int         REG_AW      = 4,
   parameter int         SYNC_STAGES = 2,
   parameter int         FILT_LEN    = 3,
   parameter logic [7:0] RST_VAL     = 8'h00
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   input  logic              usr_we,
   input  logic [REG_AW-1:0] usr_addr,
   input  logic [7:0]        usr_wdata,
   output logic [7:0]        usr_rdata,
   output logic              i2c_wr_stb,
   output logic [REG_AW-1:0] i2c_wr_addr,
   output logic [7:0]        i2c_wr_data,
   output logic              busy
);
   localparam int NUM_REGS = 2**REG_AW;
   localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, PTR = 3'd2, WDATA = 3'd3, RDATA = 3'd4, IGNORE = 3'd5;

   logic [SYNC_STAGES-1:0] scl_s, sda_s;
   logic [1:0]             raw, filt, filt_q;
   logic [1:0][3:0]        cnt;
   logic                   scl_rise, scl_fall, sda_rise, sda_fall, fall_d;
   logic                   start, stop, active, byte_end, ack_end, i2c_we, addr_hit, ptr_ok;
   logic [2:0]             state;
   logic [3:0]             bitcnt;
   logic                   ack, mack;
   logic [7:0]             sr, tx;
   logic [REG_AW-1:0]      ptr, ptr_nx;
   logic [7:0]             regs [NUM_REGS];

   assign raw      = {scl_s[SYNC_STAGES-1], sda_s[SYNC_STAGES-1]};
   assign scl_rise = filt[1] & ~filt_q[1];
   assign scl_fall = ~filt[1] & filt_q[1];
   assign sda_rise = filt[0] & ~filt_q[0];
   assign sda_fall = ~filt[0] & filt_q[0];
   assign start    = sda_fall & filt[1];
   assign stop     = sda_rise & filt[1];
   assign active   = (state != IDLE) && (state != IGNORE);
   assign byte_end = fall_d & active & ~ack & (bitcnt == 4'd8);
   assign ack_end  = fall_d & active & ack;
   assign i2c_we   = byte_end & (state == WDATA);
   assign addr_hit = sr[7:1] == I2C_ADDR;
   assign ptr_ok   = (sr >> REG_AW) == 8'd0;
   assign ptr_nx   = ptr + REG_AW'(1);
   assign usr_rdata = regs[usr_addr];

   // filtered lines only follow the synchroniser after FILT_LEN equal samples
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         scl_s  <= '1;
         sda_s  <= '1;
         filt   <= '1;
         filt_q <= '1;
         cnt    <= '0;
         fall_d <= 1'b0;
      end else begin
         scl_s  <= {scl_s[SYNC_STAGES-2:0], scl_i};
         sda_s  <= {sda_s[SYNC_STAGES-2:0], sda_i};
         filt_q <= filt;
         fall_d <= scl_fall;
         for (int i = 0; i < 2; i++)
            if (raw[i] == filt[i]) cnt[i] <= '0;
            else if (cnt[i] == 4'(FILT_LEN-1)) begin
               filt[i] <= raw[i];
               cnt[i]  <= '0;
            end else cnt[i] <= cnt[i] + 4'd1;
      end

   // SDA only changes on fall_d, one cycle after SCL is seen low
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         state       <= IDLE;
         busy        <= 1'b0;
         sda_oe      <= 1'b0;
         bitcnt      <= '0;
         ack         <= 1'b0;
         mack        <= 1'b1;
         sr          <= '0;
         tx          <= '0;
         ptr         <= '0;
         i2c_wr_stb  <= 1'b0;
         i2c_wr_addr <= '0;
         i2c_wr_data <= '0;
      end else begin
         i2c_wr_stb <= i2c_we;
         if (i2c_we) begin
            i2c_wr_addr <= ptr;
            i2c_wr_data <= sr;
         end
         if (start) begin
            state  <= ADDR;
            busy   <= 1'b1;
            bitcnt <= '0;
            ack    <= 1'b0;
            sda_oe <= 1'b0;
         end else if (stop) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sda_oe <= 1'b0;
         end else if (scl_rise && active) begin
            if (ack) mack <= filt[0];
            else begin
               sr     <= {sr[6:0], filt[0]};
               bitcnt <= bitcnt + 4'd1;
            end
         end else if (byte_end) begin
            ack <= 1'b1;
            case (state)
               ADDR: begin
                  sda_oe <= addr_hit;
                  if (!addr_hit) state <= IGNORE;
               end
               PTR: begin
                  sda_oe <= ptr_ok;
                  if (ptr_ok) ptr <= sr[REG_AW-1:0];
                  else state <= IGNORE;
               end
               WDATA: begin
                  sda_oe <= 1'b1;
                  ptr    <= ptr_nx;
               end
               default: sda_oe <= 1'b0;
            endcase
         end else if (ack_end) begin
            ack    <= 1'b0;
            bitcnt <= '0;
            sda_oe <= 1'b0;
            case (state)
               ADDR:
                  if (sr[0]) begin
                     state  <= RDATA;
                     tx     <= regs[ptr];
                     sda_oe <= ~regs[ptr][7];
                  end else state <= PTR;
               PTR: state <= WDATA;
               RDATA: begin
                  ptr <= ptr_nx;
                  if (mack) state <= IGNORE;
                  else begin
                     tx     <= regs[ptr_nx];
                     sda_oe <= ~regs[ptr_nx][7];
                  end
               end
               default: ;
            endcase
         end else if (fall_d && active && state == RDATA)
            sda_oe <= ~tx[3'd7 - bitcnt[2:0]];
      end

   // on a same-address collision the I2C write wins
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
      else
         for (int i = 0; i < NUM_REGS; i++)
            if (i2c_we && ptr == REG_AW'(i)) regs[i] <= sr;
            else if (usr_we && usr_addr == REG_AW'(i)) regs[i] <= usr_wdata;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bus-level I2C controller driving the target, checked against
// an array model of the register file, pointer and expected write strobes.
module tb_i2c_target_regfile;
   localparam int Q = 10;
   logic       clk = 1'b0, rst, scl_m, sda_m, g, usr_we;
   logic [3:0] usr_addr, i2c_wr_addr;
   logic [7:0] usr_wdata, usr_rdata, i2c_wr_data;
   logic       sda_oe, i2c_wr_stb, busy, sda_bus;
   int         n_cmp = 0, n_err = 0;
   int         m_ptr;
   logic [7:0] m_regs [16];
   logic [11:0] exp_q[$], got_q[$];
   bit         oe_seen;

   assign sda_bus = (sda_m & ~sda_oe) ^ g;

   i2c_target_regfile dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
      .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata), .usr_rdata(usr_rdata),
      .i2c_wr_stb(i2c_wr_stb), .i2c_wr_addr(i2c_wr_addr), .i2c_wr_data(i2c_wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (i2c_wr_stb) got_q.push_back({i2c_wr_addr, i2c_wr_data});
      if (sda_oe) oe_seen = 1'b1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b0; cyc(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b1; cyc(Q);
   endtask

   task automatic clk_bit(input bit d, input bit gl, output bit q);
      sda_m = d; cyc(Q);
      scl_m = 1'b1; cyc(Q/2);
      if (gl) begin
         g = 1'b1; cyc(1); g = 1'b0;
      end
      cyc(Q/2);
      q = sda_bus;
      cyc(Q);
      scl_m = 1'b0; cyc(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, input bit gl, output bit a);
      bit q;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], gl, q);
      clk_bit(1'b1, 1'b0, a);
   endtask

   task automatic rd_byte(input bit mack, output logic [7:0] b);
      bit q;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, 1'b0, q);
         b[i] = q;
      end
      clk_bit(mack, 1'b0, q);
   endtask

   task automatic cmp_stb;
      chk("stb_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("stb_addr_data", got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_regs;
      for (int i = 0; i < 16; i++) begin
         usr_addr = 4'(i); #1;
         chk("reg", usr_rdata, m_regs[i]);
      end
   endtask

   task automatic usr_write(input int a, input logic [7:0] d);
      usr_addr = 4'(a); usr_wdata = d; usr_we = 1'b1;
      cyc(1);
      usr_we = 1'b0;
      m_regs[a] = d;
   endtask

   task automatic i2c_write(input logic [7:0] p, input int n, input logic [7:0] d [8]);
      bit a;
      i2c_start;
      chk("busy_start", busy, 1);
      wr_byte(8'h52, 1'b0, a); chk("wr_addr_ack", a, 0);
      wr_byte(p, 1'b0, a);     chk("ptr_ack", a, 0);
      m_ptr = p;
      for (int i = 0; i < n; i++) begin
         wr_byte(d[i], 1'b0, a); chk("data_ack", a, 0);
         m_regs[m_ptr] = d[i];
         exp_q.push_back({4'(m_ptr), d[i]});
         m_ptr = (m_ptr + 1) % 16;
      end
      i2c_stop;
      chk("busy_stop", busy, 0);
      cmp_stb;
   endtask

   task automatic i2c_read(input int n);
      bit a;
      logic [7:0] b;
      i2c_start;
      wr_byte(8'h53, 1'b0, a); chk("rd_addr_ack", a, 0);
      for (int i = 0; i < n; i++) begin
         rd_byte(i == n - 1, b);
         chk("rd_data", b, m_regs[m_ptr]);
         m_ptr = (m_ptr + 1) % 16;
      end
      chk("rd_release", sda_oe, 0);
      i2c_stop;
      chk("busy_after_rd", busy, 0);
   endtask

   initial begin
      bit a;
      logic [7:0] b, e;
      logic [7:0] d [8];
      int n, p;
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; g = 1'b0;
      usr_we = 1'b0; usr_addr = '0; usr_wdata = '0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr = 0;
      cyc(3);
      rst = 1'b0;
      cyc(2);
      chk("rst_busy", busy, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_stb", i2c_wr_stb, 0);
      chk_regs;
      i2c_read(1);

      d[0] = 8'hA5;
      i2c_write(8'h03, 1, d);
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      i2c_write(8'h0E, 3, d);
      chk_regs;

      for (int k = 0; k < 3; k++) begin
         p = $urandom_range(0, 15);
         n = $urandom_range(1, 5);
         for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
         i2c_write(8'(p), n, d);
      end
      chk_regs;
      for (int k = 0; k < 3; k++) begin
         p = $urandom_range(0, 15);
         n = $urandom_range(1, 4);
         i2c_write(8'(p), 0, d);
         i2c_read(n);
      end

      // pointer write, repeated START, read two bytes while user rewrites the loaded one
      usr_write(5, 8'h5A);
      i2c_start;
      wr_byte(8'h52, 1'b0, a); chk("t3_addr_ack", a, 0);
      wr_byte(8'h05, 1'b0, a); chk("t3_ptr_ack", a, 0);
      m_ptr = 5;
      i2c_start;
      chk("t3_busy_sr", busy, 1);
      wr_byte(8'h53, 1'b0, a); chk("t3_rd_addr_ack", a, 0);
      e = m_regs[5];
      usr_write(5, 8'hC3);
      rd_byte(1'b0, b); chk("t3_byte0", b, e);
      rd_byte(1'b1, b); chk("t3_byte1", b, m_regs[6]);
      m_ptr = 7;
      chk("t3_release", sda_oe, 0);
      i2c_stop;
      i2c_read(1);
      cmp_stb;
      chk_regs;

      oe_seen = 1'b0;
      i2c_start;
      wr_byte(8'h54, 1'b0, a); chk("t4_addr_nack", a, 1);
      wr_byte(8'h01, 1'b0, a); chk("t4_ptr_nack", a, 1);
      wr_byte(8'hFF, 1'b0, a); chk("t4_data_nack", a, 1);
      i2c_stop;
      chk("t4_oe_never", oe_seen, 0);
      cmp_stb;
      chk_regs;

      i2c_start;
      wr_byte(8'h52, 1'b0, a); chk("t5_addr_ack", a, 0);
      wr_byte(8'h20, 1'b0, a); chk("t5_ptr_nack", a, 1);
      wr_byte(8'h77, 1'b0, a); chk("t5_data_ignored", a, 1);
      i2c_stop;
      cmp_stb;
      chk_regs;
      i2c_read(1);

      g = 1'b1; cyc(1); g = 1'b0; cyc(Q);
      chk("t6_idle_glitch", busy, 0);
      i2c_start;
      wr_byte(8'h52, 1'b0, a); chk("t6_addr_ack", a, 0);
      wr_byte(8'h0B, 1'b1, a); chk("t6_ptr_ack_glitch", a, 0);
      wr_byte(8'hA5, 1'b1, a); chk("t6_data_ack_glitch", a, 0);
      chk("t6_busy_glitch", busy, 1);
      m_regs[11] = 8'hA5;
      exp_q.push_back({4'd11, 8'hA5});
      m_ptr = 12;
      i2c_stop;
      cmp_stb;
      chk_regs;

      usr_write(9, 8'h3C);
      i2c_write(8'h09, 0, d);
      i2c_start;
      wr_byte(8'h53, 1'b0, a); chk("t6_rd_addr_ack", a, 0);
      for (int i = 0; i < 50 && !sda_oe; i++) cyc(1);
      chk("t6_oe_before_rst", sda_oe, 1);
      @(posedge clk); #3;
      rst = 1'b1; #1;
      chk("t6_rst_oe", sda_oe, 0);
      chk("t6_rst_busy", busy, 0);
      scl_m = 1'b1; sda_m = 1'b1;
      cyc(2);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr = 0;
      got_q.delete();
      cyc(2 * Q);
      chk("t6_busy_after", busy, 0);
      chk_regs;
      d[0] = 8'($urandom); d[1] = 8'($urandom);
      i2c_write(8'h0F, 2, d);
      i2c_write(8'h0F, 0, d);
      i2c_read(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
